// File: rtl/pc_gen.sv
// Program-counter generator for the FRiscV fetch path: registered PC with
// stall, PC-relative branch, JALR, direct/vectored trap redirection and a retire counter.
module pc_gen #(
    parameter int PC_WIDTH     = 32,
    parameter int RESET_VECTOR = 0,
    parameter int ALIGN_BYTES  = 4,
    parameter int CNT_WIDTH    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_in,
    input  logic                 branch_in,
    input  logic                 jump_reg_in,
    input  logic [PC_WIDTH-1:0]  imm_in,
    input  logic [PC_WIDTH-1:0]  rs1_in,
    input  logic                 trap_in,
    input  logic                 trap_int_in,
    input  logic [4:0]           trap_cause_in,
    input  logic [PC_WIDTH-1:0]  trap_vec_in,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic [PC_WIDTH-1:0]  pc_next_out,
    output logic                 misalign_out,
    output logic [PC_WIDTH-1:0]  bad_addr_out,
    output logic [CNT_WIDTH-1:0] instret_out
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(ALIGN_BYTES - 1);
    localparam logic [PC_WIDTH-1:0] ALIGN_STEP = PC_WIDTH'(ALIGN_BYTES);
    localparam logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_VECTOR);

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_STALL,
        SEL_JALR,
        SEL_BRANCH,
        SEL_SEQ
    } pc_sel_e;

    function automatic logic is_misaligned(input logic [PC_WIDTH-1:0] addr);
        return (addr & ALIGN_MASK) != {PC_WIDTH{1'b0}};
    endfunction

    logic [PC_WIDTH-1:0]  pc_r;
    logic                 misalign_r;
    logic [PC_WIDTH-1:0]  bad_addr_r;
    logic [CNT_WIDTH-1:0] instret_r;

    logic [PC_WIDTH-1:0]  seq_target_s;
    logic [PC_WIDTH-1:0]  branch_target_s;
    logic [PC_WIDTH-1:0]  jalr_sum_s;
    logic [PC_WIDTH-1:0]  jalr_target_s;
    logic [PC_WIDTH-1:0]  trap_base_s;
    logic [PC_WIDTH-1:0]  trap_target_s;
    logic [PC_WIDTH-1:0]  redirect_target_s;
    logic [PC_WIDTH-1:0]  pc_next_s;
    logic [PC_WIDTH-1:0]  bad_addr_next_s;
    logic                 misalign_next_s;
    logic                 retire_s;
    pc_sel_e              pc_sel_s;

    assign seq_target_s    = pc_r + ALIGN_STEP;
    assign branch_target_s = pc_r + imm_in;
    assign jalr_sum_s      = rs1_in + imm_in;
    assign jalr_target_s   = {jalr_sum_s[PC_WIDTH-1:1], 1'b0};
    assign trap_base_s     = {trap_vec_in[PC_WIDTH-1:2], 2'b00};

    // Trap target: only mode 1 with an interrupt uses the cause-indexed vector table
    always_comb begin
        trap_target_s = trap_base_s;
        case (trap_vec_in[1:0])
            2'b01: begin
                if (trap_int_in) begin
                    trap_target_s = trap_base_s + PC_WIDTH'({trap_cause_in, 2'b00});
                end else begin
                    trap_target_s = trap_base_s;
                end
            end
            default: trap_target_s = trap_base_s;
        endcase
    end

    // Next-PC source selection, trap highest and sequential lowest
    always_comb begin
        pc_sel_s = SEL_SEQ;
        if (trap_in) begin
            pc_sel_s = SEL_TRAP;
        end else if (stall_in) begin
            pc_sel_s = SEL_STALL;
        end else if (jump_reg_in) begin
            pc_sel_s = SEL_JALR;
        end else if (branch_in) begin
            pc_sel_s = SEL_BRANCH;
        end else begin
            pc_sel_s = SEL_SEQ;
        end
    end

    // Next-state values for PC, misalign capture and retire strobe
    always_comb begin
        pc_next_s         = pc_r;
        misalign_next_s   = 1'b0;
        bad_addr_next_s   = bad_addr_r;
        retire_s          = 1'b0;
        redirect_target_s = branch_target_s;
        case (pc_sel_s)
            SEL_TRAP: begin
                pc_next_s = trap_target_s;
            end
            SEL_STALL: begin
                pc_next_s = pc_r;
            end
            SEL_JALR, SEL_BRANCH: begin
                if (pc_sel_s == SEL_JALR) begin
                    redirect_target_s = jalr_target_s;
                end else begin
                    redirect_target_s = branch_target_s;
                end
                // A misaligned redirect holds the PC and records the bad address for the trap handler
                if (is_misaligned(redirect_target_s)) begin
                    pc_next_s       = pc_r;
                    misalign_next_s = 1'b1;
                    bad_addr_next_s = redirect_target_s;
                end else begin
                    pc_next_s = redirect_target_s;
                    retire_s  = 1'b1;
                end
            end
            SEL_SEQ: begin
                pc_next_s = seq_target_s;
                retire_s  = 1'b1;
            end
            default: begin
                pc_next_s = pc_r;
            end
        endcase
    end

    // PC, misalign pulse and bad-address registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            misalign_r <= 1'b0;
            bad_addr_r <= {PC_WIDTH{1'b0}};
        end else begin
            pc_r       <= pc_next_s;
            misalign_r <= misalign_next_s;
            bad_addr_r <= bad_addr_next_s;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= {CNT_WIDTH{1'b0}};
        end else if (retire_s) begin
            instret_r <= instret_r + CNT_WIDTH'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    assign pc_out       = pc_r;
    assign pc_next_out  = pc_next_s;
    assign misalign_out = misalign_r;
    assign bad_addr_out = bad_addr_r;
    assign instret_out  = instret_r;

endmodule
